// File: rtl/adder_accumulator_if.sv
// Handshake and result bundle between the accumulator and its producer/consumer.
interface adder_accumulator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/adder_accumulator.sv
// Sums N_TERMS handshaked terms modulo 2^WIDTH with a sticky carry flag,
// then holds the result until the consumer accepts it.
module adder_accumulator #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned N_TERMS = 4
) (
  input  logic               clk,
  input  logic               rst,
  adder_accumulator_if.slave bus
);

  localparam int unsigned CW = $clog2(N_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [CW-1:0]    cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH:0]   sum_c;

  // Extra bit captures the carry-out of this transfer's addition.
  assign sum_c = {1'b0, acc} + {1'b0, bus.in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc        <= '0;
            ovf        <= 1'b0;
            cnt        <= '0;
            state      <= ACCUM;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= sum_c[WIDTH-1:0];
            ovf <= ovf | sum_c[WIDTH];
            cnt <= cnt + CW'(1);
            // Final term: result becomes visible on the very next cycle.
            if (cnt == CW'(N_TERMS - 1)) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.start) begin
              acc        <= '0;
              ovf        <= 1'b0;
              cnt        <= '0;
              state      <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// compares every cycle out_valid is high and pops on acceptance.
module tb_adder_accumulator;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned N_TERMS = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  adder_accumulator_if #(.WIDTH(WIDTH)) bus ();

  adder_accumulator #(.WIDTH(WIDTH), .N_TERMS(N_TERMS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: result must match and stay stable for every valid cycle.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got sum=%0d ovf=%0d expected none at %0t",
                 bus.out_sum, bus.out_ovf, $time);
      end else begin
        if (bus.out_sum !== exp_q[0].sum || bus.out_ovf !== exp_q[0].ovf) begin
          n_err++;
          $display("FAIL result: got sum=%0d ovf=%0d expected sum=%0d ovf=%0d at %0t",
                   bus.out_sum, bus.out_ovf, exp_q[0].sum, exp_q[0].ovf, $time);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_exp(input int s, input int o);
    exp_t e;
    e.sum = WIDTH'(s);
    e.ovf = 1'(o);
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(d);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic run4(input int a, input int b, input int c, input int d,
                      input int es, input int eo, input string name);
    push_exp(es, eo);
    do_start();
    send(a); send(b); send(c); send(d);
    chk({name, "_valid_latency"}, int'(bus.out_valid), 1);
    @(posedge clk); #1;
    chk({name, "_idle_after"}, int'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_without_start", int'(bus.busy), 0);

    // Basic sum
    run4(1, 1, 2, 3, 7, 0, "basic");

    // Overflow
    run4(200, 100, 0, 0, 44, 1, "ovf_200_100");

    // Terms in IDLE are ignored
    bus.in_valid = 1'b1; bus.in_data = 8'd99;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("idle_ignores_data", int'(bus.busy), 0);

    // Backpressure: input bubbles and held-off consumer
    push_exp(11, 0);
    do_start();
    send(5);
    repeat (2) @(posedge clk);
    #1;
    chk("bubble_in_ready", int'(bus.in_ready), 1);
    send(6); send(0);
    bus.out_ready = 1'b0;
    send(0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after", int'(bus.busy), 0);

    // Back-to-back: overflowed result followed by a clean one
    push_exp(0, 1);
    do_start();
    send(255); send(1); send(0); send(0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_in_ready", int'(bus.in_ready), 1);
    chk("b2b_out_valid", int'(bus.out_valid), 0);
    push_exp(8, 0);
    send(2); send(2); send(2); send(2);
    @(posedge clk); #1;
    chk("b2b_idle_after", int'(bus.busy), 0);

    // Start pulsed mid-accumulation is ignored
    push_exp(18, 0);
    do_start();
    send(3); send(4);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_start_in_ready", int'(bus.in_ready), 1);
    send(5); send(6);
    @(posedge clk); #1;

    // Reset mid-accumulation discards the partial sum
    do_start();
    send(10); send(20);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", int'(bus.busy), 0);
    run4(1, 2, 3, 4, 10, 0, "after_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
